// File: rtl/psram_cmd_pacer_pkg.sv
// Shared constants and types for the PSRAM command pacer.
package psram_cmd_pacer_pkg;

    localparam logic        PSRAM_CMD_READ    = 1'b0;
    localparam logic        PSRAM_CMD_WRITE   = 1'b1;
    localparam int unsigned PSRAM_TCMD        = 14;
    localparam int unsigned PSRAM_BURST_BEATS = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } pacer_state_e;

endpackage

// File: rtl/psram_read_tracker.sv
// Read-burst tracker: waits for the burst's beats, forwards them with an index,
// flags a done pulse on the last beat, and records timeouts and stray data.
module psram_read_tracker
    import psram_cmd_pacer_pkg::*;
#(
    parameter int unsigned BEATS      = PSRAM_BURST_BEATS,
    parameter int unsigned RD_TIMEOUT = 63
) (
    input  logic        clk,
    input  logic        sys_resetn,
    input  logic        i_rd_accept,
    input  logic [63:0] i_mem_rd_data,
    input  logic        i_mem_rd_data_valid,
    output logic        o_rd_pending,
    output logic [63:0] o_rd_data,
    output logic        o_rd_data_valid,
    output logic [1:0]  o_rd_beat,
    output logic        o_rd_done,
    output logic        o_timeout_err,
    output logic        o_stray_err
);

    localparam int unsigned TO_W = $clog2(RD_TIMEOUT + 1);

    pacer_state_e    r_state;
    logic [1:0]      r_beat_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic [63:0]     r_rd_data;
    logic            r_rd_valid;
    logic [1:0]      r_rd_beat;
    logic            r_rd_done;
    logic            r_timeout_err;
    logic            r_stray_err;

    logic w_last_beat;
    logic w_timeout;

    assign w_last_beat = (r_beat_cnt == 2'(BEATS - 1));
    // to_cnt is 0 in the first RD_WAIT cycle, so the timeout edge is taken in
    // cycle accept+RD_TIMEOUT-1 and the error is visible at accept+RD_TIMEOUT.
    assign w_timeout   = (r_to_cnt >= TO_W'(RD_TIMEOUT - 2));

    // Read FSM, counters, beat register and sticky error flags.
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_state       <= IDLE;
            r_beat_cnt    <= 2'd0;
            r_to_cnt      <= '0;
            r_rd_data     <= 64'd0;
            r_rd_valid    <= 1'b0;
            r_rd_beat     <= 2'd0;
            r_rd_done     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_stray_err   <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_rd_done  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_mem_rd_data_valid) begin
                        r_stray_err <= 1'b1;
                    end
                    if (i_rd_accept) begin
                        r_state    <= RD_WAIT;
                        r_beat_cnt <= 2'd0;
                        r_to_cnt   <= '0;
                    end
                end
                RD_WAIT: begin
                    if (w_timeout) begin
                        // Timeout wins over a beat arriving in the same cycle.
                        r_state       <= IDLE;
                        r_timeout_err <= 1'b1;
                    end else begin
                        if (r_to_cnt != TO_W'(RD_TIMEOUT)) begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                        if (i_mem_rd_data_valid) begin
                            r_rd_data  <= i_mem_rd_data;
                            r_rd_valid <= 1'b1;
                            r_rd_beat  <= r_beat_cnt;
                            r_beat_cnt <= r_beat_cnt + 2'd1;
                            if (w_last_beat) begin
                                r_rd_done <= 1'b1;
                                r_state   <= IDLE;
                            end
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_rd_pending    = (r_state == RD_WAIT);
    assign o_rd_data       = r_rd_data;
    assign o_rd_data_valid = r_rd_valid;
    assign o_rd_beat       = r_rd_beat;
    assign o_rd_done       = r_rd_done;
    assign o_timeout_err   = r_timeout_err;
    assign o_stray_err     = r_stray_err;

endmodule

// File: rtl/psram_cmd_pacer.sv
// Command pacer in front of the PSRAM controller: enforces the command gap,
// holds off new commands while a read burst is outstanding, and forwards beats.
module psram_cmd_pacer
    import psram_cmd_pacer_pkg::*;
#(
    parameter int unsigned TCMD       = PSRAM_TCMD,
    parameter int unsigned BEATS      = PSRAM_BURST_BEATS,
    parameter int unsigned RD_TIMEOUT = 63,
    parameter int unsigned ADDR_W     = 21
) (
    input  logic              clk,
    input  logic              sys_resetn,
    input  logic              calib,
    input  logic              up_cmd_en,
    input  logic              up_cmd,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [63:0]       up_wr_data,
    input  logic [7:0]        up_data_mask,
    output logic              up_ready,
    output logic [63:0]       up_rd_data,
    output logic              up_rd_data_valid,
    output logic [1:0]        up_rd_beat,
    output logic              up_rd_done,
    output logic              mem_cmd_en,
    output logic              mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wr_data,
    output logic [7:0]        mem_data_mask,
    input  logic [63:0]       mem_rd_data,
    input  logic              mem_rd_data_valid,
    output logic              rd_timeout_err,
    output logic              rd_stray_err
);

    localparam int unsigned GAP_W = $clog2(TCMD);

    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_calib;
    logic             w_accept;
    logic             w_rd_accept;
    logic             w_rd_pending;

    // Ready is built only from registered state; the done cycle is excluded so
    // ready returns the cycle after the last beat is presented upstream.
    assign up_ready    = r_calib && (r_gap_cnt == '0) && !w_rd_pending && !up_rd_done;
    assign w_accept    = up_cmd_en && up_ready;
    assign w_rd_accept = w_accept && (up_cmd == PSRAM_CMD_READ);

    assign mem_cmd_en    = w_accept;
    assign mem_cmd       = up_cmd;
    assign mem_addr      = up_addr;
    assign mem_wr_data   = up_wr_data;
    assign mem_data_mask = up_data_mask;

    // Command gap counter and registered calibration status.
    always_ff @(posedge clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            r_gap_cnt <= '0;
            r_calib   <= 1'b0;
        end else begin
            r_calib <= calib;
            if (w_accept) begin
                r_gap_cnt <= GAP_W'(TCMD - 1);
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    psram_read_tracker #(
        .BEATS      (BEATS),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) u_read_tracker (
        .clk                 (clk),
        .sys_resetn          (sys_resetn),
        .i_rd_accept         (w_rd_accept),
        .i_mem_rd_data       (mem_rd_data),
        .i_mem_rd_data_valid (mem_rd_data_valid),
        .o_rd_pending        (w_rd_pending),
        .o_rd_data           (up_rd_data),
        .o_rd_data_valid     (up_rd_data_valid),
        .o_rd_beat           (up_rd_beat),
        .o_rd_done           (up_rd_done),
        .o_timeout_err       (rd_timeout_err),
        .o_stray_err         (rd_stray_err)
    );

endmodule

// File: tb/tb_psram_cmd_pacer.sv
// Randomized bench for psram_cmd_pacer against a cycle-arithmetic reference model.
module tb_psram_cmd_pacer;

    localparam int unsigned TCMD       = 14;
    localparam int unsigned BEATS      = 4;
    localparam int unsigned RD_TIMEOUT = 63;
    localparam int unsigned ADDR_W     = 21;

    logic              clk = 1'b0;
    logic              sys_resetn = 1'b0;
    logic              calib = 1'b0;
    logic              up_cmd_en = 1'b0;
    logic              up_cmd = 1'b0;
    logic [ADDR_W-1:0] up_addr = '0;
    logic [63:0]       up_wr_data = '0;
    logic [7:0]        up_data_mask = '0;
    logic              up_ready;
    logic [63:0]       up_rd_data;
    logic              up_rd_data_valid;
    logic [1:0]        up_rd_beat;
    logic              up_rd_done;
    logic              mem_cmd_en;
    logic              mem_cmd;
    logic [ADDR_W-1:0] mem_addr;
    logic [63:0]       mem_wr_data;
    logic [7:0]        mem_data_mask;
    logic [63:0]       mem_rd_data = '0;
    logic              mem_rd_data_valid = 1'b0;
    logic              rd_timeout_err;
    logic              rd_stray_err;

    always #5 clk = ~clk;

    psram_cmd_pacer #(
        .TCMD       (TCMD),
        .BEATS      (BEATS),
        .RD_TIMEOUT (RD_TIMEOUT),
        .ADDR_W     (ADDR_W)
    ) dut (
        .clk               (clk),
        .sys_resetn        (sys_resetn),
        .calib             (calib),
        .up_cmd_en         (up_cmd_en),
        .up_cmd            (up_cmd),
        .up_addr           (up_addr),
        .up_wr_data        (up_wr_data),
        .up_data_mask      (up_data_mask),
        .up_ready          (up_ready),
        .up_rd_data        (up_rd_data),
        .up_rd_data_valid  (up_rd_data_valid),
        .up_rd_beat        (up_rd_beat),
        .up_rd_done        (up_rd_done),
        .mem_cmd_en        (mem_cmd_en),
        .mem_cmd           (mem_cmd),
        .mem_addr          (mem_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_data_mask     (mem_data_mask),
        .mem_rd_data       (mem_rd_data),
        .mem_rd_data_valid (mem_rd_data_valid),
        .rd_timeout_err    (rd_timeout_err),
        .rd_stray_err      (rd_stray_err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: timing derived from cycle numbers of accepts and beats.
    logic        m_calib;
    int          m_last_acc;
    logic        m_rd_open;
    int          m_rd_acc;
    int          m_rd_beats;
    logic        m_valid;
    logic [63:0] m_data;
    logic [1:0]  m_beat;
    logic        m_done;
    logic        m_tout;
    logic        m_stray;
    int          en_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic model_ready();
        return m_calib && ((cyc - m_last_acc) >= int'(TCMD)) && !m_rd_open && !m_done;
    endfunction

    task automatic model_reset();
        m_calib    = 1'b0;
        m_last_acc = -100000;
        m_rd_open  = 1'b0;
        m_rd_acc   = 0;
        m_rd_beats = 0;
        m_valid    = 1'b0;
        m_data     = '0;
        m_beat     = '0;
        m_done     = 1'b0;
        m_tout     = 1'b0;
        m_stray    = 1'b0;
    endtask

    // Called at posedge+1; drives one cycle, checks, advances the model.
    task automatic do_cycle(input logic cal, input logic en, input logic cmd, input logic vld);
        logic exp_rdy;
        logic acc;
        calib             = cal;
        up_cmd_en         = en;
        up_cmd            = cmd;
        up_addr           = ADDR_W'($urandom);
        up_wr_data        = {$urandom, $urandom};
        up_data_mask      = 8'($urandom);
        mem_rd_data_valid = vld;
        mem_rd_data       = {$urandom, $urandom};
        #1;
        exp_rdy = model_ready();
        acc     = en && exp_rdy;
        chk("up_ready", 64'(up_ready), 64'(exp_rdy));
        chk("mem_cmd_en", 64'(mem_cmd_en), 64'(acc));
        chk("mem_cmd", 64'(mem_cmd), 64'(cmd));
        chk("mem_addr", 64'(mem_addr), 64'(up_addr));
        chk("mem_wr_data", mem_wr_data, up_wr_data);
        chk("mem_data_mask", 64'(mem_data_mask), 64'(up_data_mask));
        chk("rd_valid", 64'(up_rd_data_valid), 64'(m_valid));
        chk("rd_done", 64'(up_rd_done), 64'(m_done));
        chk("timeout_err", 64'(rd_timeout_err), 64'(m_tout));
        chk("stray_err", 64'(rd_stray_err), 64'(m_stray));
        if (m_valid) begin
            chk("rd_data", up_rd_data, m_data);
            chk("rd_beat", 64'(up_rd_beat), 64'(m_beat));
        end
        if (mem_cmd_en) en_log.push_back(cyc);

        m_valid = 1'b0;
        m_done  = 1'b0;
        if (m_rd_open) begin
            if ((cyc - m_rd_acc) == int'(RD_TIMEOUT) - 1) begin
                m_tout    = 1'b1;
                m_rd_open = 1'b0;
            end else if (vld) begin
                m_valid = 1'b1;
                m_data  = mem_rd_data;
                m_beat  = 2'(m_rd_beats);
                m_rd_beats++;
                if (m_rd_beats == int'(BEATS)) begin
                    m_done    = 1'b1;
                    m_rd_open = 1'b0;
                end
            end
        end else if (vld) begin
            m_stray = 1'b1;
        end
        if (acc) begin
            m_last_acc = cyc;
            if (cmd == 1'b0) begin
                m_rd_open  = 1'b1;
                m_rd_acc   = cyc;
                m_rd_beats = 0;
            end
        end
        m_calib = cal;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_up_ready", 64'(up_ready), 64'd0);
        chk("rst_mem_cmd_en", 64'(mem_cmd_en), 64'd0);
        chk("rst_rd_data", up_rd_data, 64'd0);
        chk("rst_rd_valid", 64'(up_rd_data_valid), 64'd0);
        chk("rst_rd_beat", 64'(up_rd_beat), 64'd0);
        chk("rst_rd_done", 64'(up_rd_done), 64'd0);
        chk("rst_timeout_err", 64'(rd_timeout_err), 64'd0);
        chk("rst_stray_err", 64'(rd_stray_err), 64'd0);
    endtask

    // Asynchronous reset pulse from mid-cycle; returns aligned at posedge+1.
    task automatic do_reset();
        calib      = 1'b1;
        up_cmd_en  = 1'b1;
        #2;
        sys_resetn = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        sys_resetn = 1'b1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 100; i++) begin
            if (model_ready()) break;
            do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int n0;
        int vp;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Not calibrated: requests ignored.
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        // Calibration arrives; ready follows one cycle later.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("calib_ready", 64'(up_ready), 64'd1);

        // Continuous write requests: accepts exactly TCMD apart.
        en_log.delete();
        for (int i = 0; i < 30; i++) do_cycle(1'b1, 1'b1, 1'b1, 1'b0);
        chk("wr_accepts", 64'(en_log.size()), 64'd3);
        if (en_log.size() >= 2) chk("wr_gap", 64'(en_log[1] - en_log[0]), 64'(TCMD));

        // Full read, beats at N+12..N+15.
        wait_ready();
        n0 = cyc;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rd_done_at_n16", 64'(up_rd_done), 64'd1);
        chk("rd_done_cyc", 64'(cyc), 64'(n0 + 16));
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("ready_at_n17", 64'(up_ready), 64'd1);

        // Short read: timeout with only three beats.
        wait_ready();
        n0 = cyc;
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        while (cyc < n0 + int'(RD_TIMEOUT) - 1) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tout_not_yet", 64'(rd_timeout_err), 64'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tout_at_n63", 64'(rd_timeout_err), 64'd1);
        for (int i = 0; i < 20; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("tout_sticky", 64'(rd_timeout_err), 64'd1);

        // Stray data while idle.
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        chk("stray_set", 64'(rd_stray_err), 64'd1);

        // Reset after beat 1, then a clean read restarting at beat 0.
        wait_ready();
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 12; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        wait_ready();
        do_cycle(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b0);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        chk("restart_beat0", 64'(up_rd_beat), 64'd0);
        for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        do_cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with varying beat density.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) vp = int'($urandom_range(0, 3));
            if (i == 1500) do_reset();
            do_cycle(($urandom_range(0, 31) != 0),
                     ($urandom_range(0, 3) == 0),
                     1'($urandom),
                     (vp == 0) ? 1'b0 :
                     (vp == 1) ? ($urandom_range(0, 15) == 0) :
                     (vp == 2) ? ($urandom_range(0, 3) == 0) :
                                 ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
